// File: rtl/circle_drawer.sv
`default_nettype none
// ============================================================================
// Module   : circle_drawer
// Purpose  : Midpoint (Bresenham) circle rasteriser feeding a 160x120, 3-bit
//            colour VGA adapter. One octant pixel is emitted per clock while
//            a job runs, so the pixel stream length depends only on radius.
//            A level start/done handshake lets a controller chain jobs.
// Revision : 1.0 - initial release
//
// Ports:
//   clk         in   1  system clock
//   rst_n       in   1  synchronous active-low reset
//   start       in   1  level job request; parameters sampled on acceptance
//   colour      in   3  circle colour
//   centre_x    in   8  centre x (0..255)
//   centre_y    in   7  centre y (0..127)
//   radius      in   8  radius (0..255)
//   done        out  1  job complete; held while start stays high
//   vga_x       out  8  pixel x to adapter
//   vga_y       out  7  pixel y to adapter
//   vga_colour  out  3  pixel colour
//   vga_plot    out  1  write strobe, one pixel per high cycle
//
// Build option:
//   CIRCLE_CLEAR_EN - when defined, every job first paints the whole screen
//                     black (column-major sweep) before drawing the circle.
// ============================================================================
module circle_drawer #(
  parameter int SCR_W = 160,
  parameter int SCR_H = 120
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [2:0] colour,
  input  logic [7:0] centre_x,
  input  logic [6:0] centre_y,
  input  logic [7:0] radius,
  output logic       done,
  output logic [7:0] vga_x,
  output logic [6:0] vga_y,
  output logic [2:0] vga_colour,
  output logic       vga_plot
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_PLOT  = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;
`ifdef CIRCLE_CLEAR_EN
  localparam logic [1:0] ST_CLEAR = 2'd3;
  localparam logic [7:0] CLR_X_LAST = 8'(SCR_W - 1);
  localparam logic [6:0] CLR_Y_LAST = 7'(SCR_H - 1);
`endif

  // 12-bit signed keeps cx+ox (max 510) and cx-ox (min -255) exact, and
  // leaves ample headroom for the decision variable.
  localparam logic signed [11:0] SCR_W_S = 12'(SCR_W);
  localparam logic signed [11:0] SCR_H_S = 12'(SCR_H);

  // --------------------------------------------------------------------------
  // State and working registers
  // --------------------------------------------------------------------------
  logic [1:0]         state_q,      state_d;
  logic [2:0]         colour_q,     colour_d;
  logic [7:0]         cx_q,         cx_d;
  logic [6:0]         cy_q,         cy_d;
  logic signed [11:0] ox_q,         ox_d;
  logic signed [11:0] oy_q,         oy_d;
  logic signed [11:0] crit_q,       crit_d;
  logic [2:0]         octant_q,     octant_d;
  logic               done_q,       done_d;
  logic [7:0]         vga_x_q,      vga_x_d;
  logic [6:0]         vga_y_q,      vga_y_d;
  logic [2:0]         vga_colour_q, vga_colour_d;
  logic               vga_plot_q,   vga_plot_d;
`ifdef CIRCLE_CLEAR_EN
  logic [7:0]         clr_x_q,      clr_x_d;
  logic [6:0]         clr_y_q,      clr_y_d;
`endif

  // --------------------------------------------------------------------------
  // Current octant pixel and next circle state
  // --------------------------------------------------------------------------
  logic signed [11:0] cx_s;
  logic signed [11:0] cy_s;
  logic signed [11:0] px;
  logic signed [11:0] py;
  logic               clipped;
  logic signed [11:0] oy_nx;
  logic signed [11:0] ox_nx;
  logic signed [11:0] crit_nx;

  always_comb begin
    cx_s = $signed({4'd0, cx_q});
    cy_s = $signed({5'd0, cy_q});
    px   = cx_s;
    py   = cy_s;
    case (octant_q)
      3'd0: begin px = cx_s + ox_q; py = cy_s + oy_q; end
      3'd1: begin px = cx_s + oy_q; py = cy_s + ox_q; end
      3'd2: begin px = cx_s - ox_q; py = cy_s + oy_q; end
      3'd3: begin px = cx_s - oy_q; py = cy_s + ox_q; end
      3'd4: begin px = cx_s - ox_q; py = cy_s - oy_q; end
      3'd5: begin px = cx_s - oy_q; py = cy_s - ox_q; end
      3'd6: begin px = cx_s + ox_q; py = cy_s - oy_q; end
      3'd7: begin px = cx_s + oy_q; py = cy_s - ox_q; end
      default: begin px = cx_s; py = cy_s; end
    endcase

    clipped = (px < 12'sd0) || (px >= SCR_W_S) ||
              (py < 12'sd0) || (py >= SCR_H_S);

    // Midpoint step: y always advances; x retreats only when the midpoint
    // lies outside the circle (positive decision variable).
    oy_nx = oy_q + 12'sd1;
    if (crit_q <= 12'sd0) begin
      ox_nx   = ox_q;
      crit_nx = crit_q + (oy_nx <<< 1) + 12'sd1;
    end else begin
      ox_nx   = ox_q - 12'sd1;
      crit_nx = crit_q + ((oy_nx - ox_nx) <<< 1) + 12'sd1;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    colour_d     = colour_q;
    cx_d         = cx_q;
    cy_d         = cy_q;
    ox_d         = ox_q;
    oy_d         = oy_q;
    crit_d       = crit_q;
    octant_d     = octant_q;
    done_d       = done_q;
    vga_x_d      = vga_x_q;
    vga_y_d      = vga_y_q;
    vga_colour_d = vga_colour_q;
    vga_plot_d   = 1'b0;
`ifdef CIRCLE_CLEAR_EN
    clr_x_d      = clr_x_q;
    clr_y_d      = clr_y_q;
`endif

    case (state_q)
      ST_IDLE: begin
        done_d = 1'b0;
        if (start) begin
          colour_d = colour;
          cx_d     = centre_x;
          cy_d     = centre_y;
          ox_d     = $signed({4'd0, radius});
          oy_d     = 12'sd0;
          crit_d   = 12'sd1 - $signed({4'd0, radius});
          octant_d = 3'd0;
`ifdef CIRCLE_CLEAR_EN
          clr_x_d  = 8'd0;
          clr_y_d  = 7'd0;
          state_d  = ST_CLEAR;
`else
          state_d  = ST_PLOT;
`endif
        end
      end

`ifdef CIRCLE_CLEAR_EN
      // Column-major black sweep; hands over to PLOT with no bubble.
      ST_CLEAR: begin
        vga_x_d      = clr_x_q;
        vga_y_d      = clr_y_q;
        vga_colour_d = 3'b000;
        vga_plot_d   = 1'b1;
        if (clr_y_q == CLR_Y_LAST) begin
          clr_y_d = 7'd0;
          if (clr_x_q == CLR_X_LAST) begin
            state_d = ST_PLOT;
          end else begin
            clr_x_d = clr_x_q + 8'd1;
          end
        end else begin
          clr_y_d = clr_y_q + 7'd1;
        end
      end
`endif

      ST_PLOT: begin
        // Clipped pixels still take their cycle so timing is radius-only.
        vga_x_d      = px[7:0];
        vga_y_d      = py[6:0];
        vga_colour_d = colour_q;
        vga_plot_d   = ~clipped;
        octant_d     = octant_q + 3'd1;
        if (octant_q == 3'd7) begin
          oy_d   = oy_nx;
          ox_d   = ox_nx;
          crit_d = crit_nx;
          if (oy_nx > ox_nx) begin
            state_d = ST_DONE;
          end
        end
      end

      ST_DONE: begin
        // The first DONE cycle always raises done, so a requester that has
        // already dropped start still sees one done pulse.
        if (!done_q || start) begin
          done_d = 1'b1;
        end else begin
          done_d  = 1'b0;
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
        done_d  = 1'b0;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      colour_q     <= 3'd0;
      cx_q         <= 8'd0;
      cy_q         <= 7'd0;
      ox_q         <= 12'sd0;
      oy_q         <= 12'sd0;
      crit_q       <= 12'sd0;
      octant_q     <= 3'd0;
      done_q       <= 1'b0;
      vga_x_q      <= 8'd0;
      vga_y_q      <= 7'd0;
      vga_colour_q <= 3'd0;
      vga_plot_q   <= 1'b0;
`ifdef CIRCLE_CLEAR_EN
      clr_x_q      <= 8'd0;
      clr_y_q      <= 7'd0;
`endif
    end else begin
      state_q      <= state_d;
      colour_q     <= colour_d;
      cx_q         <= cx_d;
      cy_q         <= cy_d;
      ox_q         <= ox_d;
      oy_q         <= oy_d;
      crit_q       <= crit_d;
      octant_q     <= octant_d;
      done_q       <= done_d;
      vga_x_q      <= vga_x_d;
      vga_y_q      <= vga_y_d;
      vga_colour_q <= vga_colour_d;
      vga_plot_q   <= vga_plot_d;
`ifdef CIRCLE_CLEAR_EN
      clr_x_q      <= clr_x_d;
      clr_y_q      <= clr_y_d;
`endif
    end
  end

  assign done       = done_q;
  assign vga_x      = vga_x_q;
  assign vga_y      = vga_y_q;
  assign vga_colour = vga_colour_q;
  assign vga_plot   = vga_plot_q;

endmodule
`default_nettype wire

// File: tb/tb_circle_drawer.sv
`default_nettype none
// ============================================================================
// Module   : tb_circle_drawer
// Purpose  : Directed self-checking bench for circle_drawer. Walks reset,
//            small known circles, a corner-clipped circle, the done/start
//            handshake and a mid-job reset.
// Revision : 1.0 - initial release
// Ports    : none (top-level bench)
// ============================================================================
module tb_circle_drawer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [2:0] colour;
  logic [7:0] centre_x;
  logic [6:0] centre_y;
  logic [7:0] radius;
  logic       done;
  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [2:0] vga_colour;
  logic       vga_plot;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  circle_drawer #(.SCR_W(160), .SCR_H(120)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .colour     (colour),
    .centre_x   (centre_x),
    .centre_y   (centre_y),
    .radius     (radius),
    .done       (done),
    .vga_x      (vga_x),
    .vga_y      (vga_y),
    .vga_colour (vga_colour),
    .vga_plot   (vga_plot)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and sample 1 ns later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Consumes the screen-clear sweep when that build option is on.
  task automatic skip_clear();
`ifdef CIRCLE_CLEAR_EN
    int bad;
    bad = 0;
    for (int x = 0; x < 160; x++) begin
      for (int y = 0; y < 120; y++) begin
        step();
        if (vga_plot !== 1'b1 || vga_colour !== 3'd0 ||
            vga_x !== 8'(x) || vga_y !== 7'(y)) bad++;
      end
    end
    check("clear_sweep_bad", bad, 0);
`endif
  endtask

  // Present a job and take edge E0; inputs stay as set afterwards.
  task automatic start_job(input logic [2:0] c, input logic [7:0] x,
                           input logic [6:0] y, input logic [7:0] r);
    colour   = c;
    centre_x = x;
    centre_y = y;
    radius   = r;
    start    = 1'b1;
    step();
    check("e0_plot", vga_plot, 0);
    skip_clear();
  endtask

  int ex1 [16] = '{81, 80, 79, 80, 79, 80, 81, 80, 81, 81, 79, 79, 79, 79, 81, 81};
  int ey1 [16] = '{60, 61, 60, 61, 60, 59, 60, 59, 61, 61, 61, 61, 59, 59, 59, 59};

  int cyc;
  int plots;
  int badr;
  int got_done;
  int d2;

  initial begin
    rst_n    = 1'b0;
    start    = 1'b0;
    colour   = 3'd0;
    centre_x = 8'd0;
    centre_y = 7'd0;
    radius   = 8'd0;

    // ---------------- reset and idle ----------------
    step(); step(); step();
    check("rst_done",   done, 0);
    check("rst_plot",   vga_plot, 0);
    check("rst_x",      vga_x, 0);
    check("rst_y",      vga_y, 0);
    check("rst_colour", vga_colour, 0);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      check("idle_done", done, 0);
      check("idle_plot", vga_plot, 0);
    end
    check("idle_x", vga_x, 0);
    check("idle_y", vga_y, 0);
    check("idle_colour", vga_colour, 0);

    // ---------------- radius 1 at (80,60) ----------------
    start_job(3'b010, 8'd80, 7'd60, 8'd1);
    for (int i = 0; i < 16; i++) begin
      step();
      check("r1_plot",   vga_plot, 1);
      check("r1_x",      vga_x, ex1[i]);
      check("r1_y",      vga_y, ey1[i]);
      check("r1_colour", vga_colour, 3'b010);
      check("r1_done",   done, 0);
    end
    step();
    check("r1_e17_done", done, 1);
    check("r1_e17_plot", vga_plot, 0);

    // done held while start stays high
    for (int i = 0; i < 30; i++) begin
      step();
      check("hold_done", done, 1);
      check("hold_plot", vga_plot, 0);
    end
    start = 1'b0;
    step();
    check("drop_done", done, 0);
    check("drop_plot", vga_plot, 0);

    // ---------------- radius 0 at (10,20), inputs changed after E0 ----------------
    start_job(3'b011, 8'd10, 7'd20, 8'd0);
    centre_x = 8'd50;
    centre_y = 7'd5;
    radius   = 8'd9;
    colour   = 3'b111;
    for (int i = 0; i < 8; i++) begin
      step();
      check("r0_plot",   vga_plot, 1);
      check("r0_x",      vga_x, 10);
      check("r0_y",      vga_y, 20);
      check("r0_colour", vga_colour, 3'b011);
    end
    step();
    check("r0_e9_done", done, 1);
    check("r0_e9_plot", vga_plot, 0);
    start = 1'b0;
    step();
    check("r0_drop_done", done, 0);

    // ---------------- radius 10 at (0,0): heavy clipping ----------------
    // Iterations (ox,oy): (10,0)(10,1)(10,2)(10,3)(9,4)(9,5)(8,6)(7,7) -> 64 cycles.
    // Visible: octants 0 and 1 every iteration, plus octants 3 and 6 at oy=0 -> 18.
    start_job(3'b111, 8'd0, 7'd0, 8'd10);
    cyc      = 0;
    plots    = 0;
    badr     = 0;
    got_done = 0;
    for (int i = 0; i < 200; i++) begin
      step();
      if (done === 1'b1) begin
        got_done = 1;
        break;
      end
      cyc++;
      if (vga_plot === 1'b1) begin
        plots++;
        d2 = int'(vga_x) * int'(vga_x) + int'(vga_y) * int'(vga_y);
        if (d2 < 90 || d2 > 110) badr++;
      end
    end
    check("r10_got_done", got_done, 1);
    check("r10_cycles",   cyc, 64);
    check("r10_plots",    plots, 18);
    check("r10_ring_bad", badr, 0);
    start = 1'b0;
    step();
    check("r10_drop_done", done, 0);

    // ---------------- reset in the middle of a job ----------------
    start_job(3'b101, 8'd80, 7'd60, 8'd5);
    step();
    check("mid_p0_plot", vga_plot, 1);
    check("mid_p0_x",    vga_x, 85);
    check("mid_p0_y",    vga_y, 60);
    step();
    check("mid_p1_x",    vga_x, 80);
    check("mid_p1_y",    vga_y, 65);
    rst_n = 1'b0;
    start = 1'b0;
    step();
    check("mid_rst_plot",   vga_plot, 0);
    check("mid_rst_done",   done, 0);
    check("mid_rst_x",      vga_x, 0);
    check("mid_rst_y",      vga_y, 0);
    check("mid_rst_colour", vga_colour, 0);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check("post_rst_plot", vga_plot, 0);
      check("post_rst_done", done, 0);
    end

    // A fresh job after the abort starts from octant 0
    start_job(3'b001, 8'd20, 7'd30, 8'd2);
    step();
    check("new_plot",   vga_plot, 1);
    check("new_x",      vga_x, 22);
    check("new_y",      vga_y, 30);
    check("new_colour", vga_colour, 3'b001);
    start = 1'b0;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
